// File: rtl/audio_clk_gen.sv
// Phase-accumulator audio bit-clock generator with I2S/TDM slot counters,
// frame sync and a lock indication.
module audio_clk_gen #(
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                         clkin,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [ACC_W-1:0]             incr,
  input  logic                         incr_valid,
  output logic                         bclk,
  output logic                         bclk_rise_stb,
  output logic                         bclk_fall_stb,
  output logic                         lrclk,
  output logic [$clog2(CHANNELS)-1:0]  slot,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic                         lock
);

  localparam int unsigned SLOT_W = $clog2(CHANNELS);
  localparam int unsigned BIT_W  = $clog2(SLOT_BITS);
  localparam int unsigned CNT_W  = $clog2(LOCK_CYCLES + 1);

  logic [ACC_W-1:0]  incr_q,  incr_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic              bclk_q,  bclk_d;
  logic              rise_q,  rise_d;
  logic              fall_q,  fall_d;
  logic              lrclk_q, lrclk_d;
  logic [SLOT_W-1:0] slot_q,  slot_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              lock_q,  lock_d;

  logic [ACC_W:0]    sum_c;
  logic              carry_c;
  logic              fall_evt_c;

  // Next-state: load/clear beats enable; carry out of the accumulator toggles bclk.
  always_comb begin
    incr_d  = incr_q;
    acc_d   = acc_q;
    bclk_d  = bclk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    lrclk_d = lrclk_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;

    sum_c      = {1'b0, acc_q} + {1'b0, incr_q};
    carry_c    = sum_c[ACC_W];
    fall_evt_c = carry_c & bclk_q;

    if (incr_valid) begin
      incr_d  = incr;
      acc_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      slot_d  = '0;
      bit_d   = '0;
      cnt_d   = '0;
      lock_d  = 1'b0;
    end else if (!enable) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end else begin
      acc_d  = sum_c[ACC_W-1:0];
      bclk_d = bclk_q ^ carry_c;
      rise_d = carry_c & ~bclk_q;
      fall_d = fall_evt_c;

      // Slot/bit position advances on the falling bclk edge.
      if (fall_evt_c) begin
        if (bit_q == BIT_W'(SLOT_BITS - 1)) begin
          bit_d  = '0;
          slot_d = (slot_q == SLOT_W'(CHANNELS - 1)) ? '0 : slot_q + SLOT_W'(1);
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
        if (CHANNELS == 2) begin
          lrclk_d = slot_d[0];
        end else begin
          lrclk_d = (slot_d == '0) && (bit_d == '0);
        end
      end

      if (incr_q != '0) begin
        if (cnt_q != CNT_W'(LOCK_CYCLES)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        lock_d = (cnt_d == CNT_W'(LOCK_CYCLES));
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      incr_q  <= '0;
      acc_q   <= '0;
      bclk_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      lrclk_q <= 1'b0;
      slot_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      incr_q  <= incr_d;
      acc_q   <= acc_d;
      bclk_q  <= bclk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      lrclk_q <= lrclk_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  assign bclk          = bclk_q;
  assign bclk_rise_stb = rise_q;
  assign bclk_fall_stb = fall_q;
  assign lrclk         = lrclk_q;
  assign slot          = slot_q;
  assign bit_idx       = bit_q;
  assign lock          = lock_q;

endmodule

// File: tb/tb_audio_clk_gen.sv
// Scoreboard bench for audio_clk_gen: an I2S instance and a 4-slot TDM
// instance share stimulus and are checked against an arithmetic model.
module tb_audio_clk_gen;

  localparam longint MOD = 64'd1 << 24;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        incr_valid;
  logic [23:0] incr;

  logic       bclk2, rise2, fall2, lrclk2, lock2;
  logic [0:0] slot2;
  logic [4:0] bit2;
  logic       bclk4, rise4, fall4, lrclk4, lock4;
  logic [1:0] slot4;
  logic [4:0] bit4;

  audio_clk_gen #(.ACC_W(24), .SLOT_BITS(32), .CHANNELS(2), .LOCK_CYCLES(16)) dut2 (
    .clkin(clk), .reset(reset), .enable(enable), .incr(incr), .incr_valid(incr_valid),
    .bclk(bclk2), .bclk_rise_stb(rise2), .bclk_fall_stb(fall2), .lrclk(lrclk2),
    .slot(slot2), .bit_idx(bit2), .lock(lock2)
  );

  audio_clk_gen #(.ACC_W(24), .SLOT_BITS(32), .CHANNELS(4), .LOCK_CYCLES(2)) dut4 (
    .clkin(clk), .reset(reset), .enable(enable), .incr(incr), .incr_valid(incr_valid),
    .bclk(bclk4), .bclk_rise_stb(rise4), .bclk_fall_stb(fall4), .lrclk(lrclk4),
    .slot(slot4), .bit_idx(bit4), .lock(lock4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accumulator as plain integers, frame position as a count of falls.
  longint m_acc, m_incr, m_nfall, m_en;
  logic   m_bclk, m_rise, m_fall;

  typedef struct {
    logic [15:0] e2;
    logic [15:0] e4;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int edge_idx, rise_cnt, fall_cnt, first_rise, lr_toggles;
  logic lr_prev;

  function automatic void model_clear(input logic full);
    if (full) m_incr = 0;
    m_acc = 0; m_nfall = 0; m_en = 0;
    m_bclk = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
  endfunction

  function automatic void model_edge(input logic r, input logic iv, input logic en,
                                     input logic [23:0] inc);
    longint s;
    logic   c;
    if (r) begin
      model_clear(1'b1);
    end else if (iv) begin
      model_clear(1'b0);
      m_incr = longint'(inc);
    end else if (!en) begin
      m_rise = 1'b0; m_fall = 1'b0; m_en = 0;
    end else begin
      s      = m_acc + m_incr;
      c      = (s >= MOD);
      m_acc  = s % MOD;
      m_rise = c && !m_bclk;
      m_fall = c && m_bclk;
      if (c) m_bclk = !m_bclk;
      if (m_fall) m_nfall++;
      if (m_incr != 0) m_en++;
    end
  endfunction

  function automatic logic [15:0] exp2();
    longint sl = (m_nfall / 32) % 2;
    longint bi = m_nfall % 32;
    return 16'({m_bclk, m_rise, m_fall, 1'(sl), 1'(sl), 5'(bi), (m_en >= 16)});
  endfunction

  function automatic logic [15:0] exp4();
    longint sl = (m_nfall / 32) % 4;
    longint bi = m_nfall % 32;
    logic   lr = (m_nfall > 0) && (m_nfall % 128 == 0);
    return 16'({m_bclk, m_rise, m_fall, lr, 2'(sl), 5'(bi), (m_en >= 2)});
  endfunction

  function automatic void check_int(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endfunction

  function automatic void check_near(input string name, input longint got, input real want,
                                     input real tol);
    real d = real'(got) - want;
    n_checks++;
    if (d <= tol && d >= -tol) n_pass++;
    else $display("FAIL %s: got %0d expected %f (+/- %f)", name, got, want, tol);
  endfunction

  function automatic logic [23:0] pick_incr();
    case ($urandom_range(0, 4))
      0:       return 24'($urandom_range(1, 255));
      1:       return 24'hFFFFFF;
      2:       return 24'h800000 + 24'($urandom_range(0, 65535));
      default: return 24'($urandom_range(1, 32'h00FF_FFFF));
    endcase
  endfunction

  // One clock: model the edge with the inputs the DUT saw, then drive the next inputs.
  task automatic step(input logic r, input logic iv, input logic en, input logic [23:0] inc);
    exp_t e;
    @(posedge clk);
    model_edge(reset, incr_valid, enable, incr);
    #1;
    edge_idx++;
    if (rise2) begin
      rise_cnt++;
      if (first_rise < 0) first_rise = edge_idx;
    end
    if (fall2) fall_cnt++;
    if (lrclk2 != lr_prev) lr_toggles++;
    lr_prev    = lrclk2;
    reset      = r;
    incr_valid = iv;
    enable     = en;
    incr       = inc;
    if (r) model_clear(1'b1);
    cyc++;
    e.e2  = exp2();
    e.e4  = exp4();
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic zero_counters();
    edge_idx = 0; rise_cnt = 0; fall_cnt = 0; first_rise = -1; lr_toggles = 0;
    lr_prev = lrclk2;
  endtask

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  initial begin : monitor
    exp_t        e;
    logic [15:0] g2, g4;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        g2 = 16'({bclk2, rise2, fall2, lrclk2, slot2, bit2, lock2});
        g4 = 16'({bclk4, rise4, fall4, lrclk4, slot4, bit4, lock4});
        n_checks++;
        if (g2 == e.e2) n_pass++;
        else $display("FAIL i2s_outputs cyc=%0d got=%h expected=%h", e.cyc, g2, e.e2);
        n_checks++;
        if (g4 == e.e4) n_pass++;
        else $display("FAIL tdm_outputs cyc=%0d got=%h expected=%h", e.cyc, g4, e.e4);
      end
    end
  end

  initial begin : stim
    int          len;
    logic        iv, en;
    logic [23:0] inc;
    reset = 1'b1; enable = 1'b0; incr_valid = 1'b0; incr = '0;
    model_clear(1'b1);
    zero_counters();
    repeat (3) step(1'b1, 1'b0, 1'b0, 24'h0);

    // Half-rate-of-half increment: bclk period 4 cycles, first rise 2 edges after load.
    step(1'b0, 1'b1, 1'b1, 24'h800000);
    step(1'b0, 1'b0, 1'b1, 24'($urandom));
    zero_counters();
    repeat (1200) step(1'b0, 1'b0, 1'b1, 24'($urandom));
    check_int("first_rise_edge", first_rise, 2);
    check_int("rises_in_1200", rise_cnt, 300);
    check_int("falls_in_1200", fall_cnt, 300);
    check_int("i2s_lr_toggles", lr_toggles, 9);

    // Enable dropouts with the same increment.
    for (int k = 0; k < 600; k++)
      step(1'b0, 1'b0, ($urandom_range(0, 99) >= 10), 24'($urandom));

    // Zero increment: never locks, never toggles.
    step(1'b0, 1'b1, 1'b1, 24'h0);
    step(1'b0, 1'b0, 1'b1, 24'($urandom));
    zero_counters();
    repeat (50) step(1'b0, 1'b0, 1'b1, 24'($urandom));
    check_int("zero_incr_rises", rise_cnt, 0);

    // 27 MHz in, 3.072 MHz bclk, 48 kHz frame.
    step(1'b0, 1'b1, 1'b1, 24'd3817750);
    step(1'b0, 1'b0, 1'b1, 24'($urandom));
    zero_counters();
    repeat (20000) step(1'b0, 1'b0, 1'b1, 24'($urandom));
    check_near("bclk_freq_rises", rise_cnt, 20000.0 * 3.072e6 / 27.0e6, 1.0);
    check_near("lrclk_48k_toggles", lr_toggles, 20000.0 * 2.0 * 48.0e3 / 27.0e6, 1.0);

    // Async reset mid-frame, then restart.
    step(1'b1, 1'b0, 1'b1, 24'($urandom));
    step(1'b0, 1'b1, 1'b1, 24'd3817750);
    repeat (300) step(1'b0, 1'b0, 1'b1, 24'($urandom));

    // Randomized segments with reloads, enable drops and async resets.
    for (int s = 0; s < 40; s++) begin
      step(1'b0, 1'b1, 1'b1, pick_incr());
      len = $urandom_range(50, 500);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 999) < 3) begin
          step(1'b1, 1'b0, 1'b1, 24'($urandom));
          iv = ($urandom_range(0, 1) == 1);
          step(1'b0, iv, 1'b1, pick_incr());
        end else begin
          en  = ($urandom_range(0, 99) >= 5);
          iv  = ($urandom_range(0, 999) < 4);
          inc = iv ? pick_incr() : 24'($urandom);
          step(1'b0, iv, en, inc);
        end
      end
    end

    repeat (4) step(1'b0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
